// File: rtl/scan_inject_base_if.sv
// Probe bundle exported by scan_inject_base: LFSR output, injection/capture strobes
// and the serial shadow-chain dump handshake.
interface scan_inject_base_if;
    logic out;
    logic err_en;
    logic err_ctrl;
    logic sh_clk;
    logic sh_rst;
    logic c_en;
    logic dump_en;
    logic ch_out;
    logic ch_out_vld;
    logic ch_out_done;

    modport master (
        output out, err_en, err_ctrl, sh_clk, sh_rst, c_en,
               dump_en, ch_out, ch_out_vld, ch_out_done
    );

    modport slave (
        input  out, err_en, err_ctrl, sh_clk, sh_rst, c_en,
               dump_en, ch_out, ch_out_vld, ch_out_done
    );
endinterface

// File: rtl/scan_inject_base.sv
// Scan fault-injection experiment: LFSR payload, single-bit fault injection, shadow capture
// and serial dump. Optional macro DUMP_PARITY_EN appends an even-parity slot to the dump.
//
// state   | meaning
// IDLE    | one cycle after reset, shadow reset asserted
// RUN     | LFSR steps for RUN_CYCLES cycles
// INJECT  | flip or clear LFSR[INJ_BIT]
// CAPTURE | shadow chain loads the LFSR
// DUMP    | two cycles per chain bit, LSB first
// DONE    | end-of-dump pulse, fault type toggles on exit
module scan_inject_base #(
    parameter int unsigned     WIDTH      = 16,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned     RUN_CYCLES = 32,
    parameter int unsigned     INJ_BIT    = 3
) (
    input  logic               clk,
    input  logic               rst,
    scan_inject_base_if.master probe
);

`ifdef DUMP_PARITY_EN
    localparam int unsigned NSLOT = WIDTH + 1;
`else
    localparam int unsigned NSLOT = WIDTH;
`endif
    localparam int unsigned DUMP_CYCLES = 2 * NSLOT;
    localparam int unsigned TMR_MAX     = (RUN_CYCLES > DUMP_CYCLES) ? RUN_CYCLES : DUMP_CYCLES;
    localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RUN_LOAD  = TMR_W'(RUN_CYCLES - 1);
    localparam logic [TMR_W-1:0] DUMP_LOAD = TMR_W'(DUMP_CYCLES - 1);
    localparam logic [WIDTH-1:0] INJ_MASK  = {{(WIDTH-1){1'b0}}, 1'b1} << INJ_BIT;
    localparam logic [NSLOT-1:0] SLOT_ONE  = {{(NSLOT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_INJECT,
        ST_CAPTURE,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   chain_q, chain_d;
    logic               err_ctrl_q, err_ctrl_d;
    logic               err_en_q, err_en_d;
    logic               c_en_q, c_en_d;
    logic               dump_en_q, dump_en_d;
    logic               sh_clk_q, sh_clk_d;
    logic               sh_rst_q, sh_rst_d;
    logic               ch_out_q, ch_out_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;

    logic               fb;
    logic [TMR_W-1:0]   slot_d;
    logic [NSLOT-1:0]   dump_vec;

    assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                tmr_d   = RUN_LOAD;
            end
            ST_RUN: begin
                if (tmr_q == '0) begin
                    state_d = ST_INJECT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_INJECT: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_DUMP;
                tmr_d   = DUMP_LOAD;
            end
            ST_DUMP: begin
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
                tmr_d   = RUN_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An all-zero LFSR would never leave zero, so the next step reloads the seed instead.
    always_comb begin
        lfsr_d = lfsr_q;
        case (state_q)
            ST_RUN:    lfsr_d = (lfsr_q == '0) ? SEED : {fb, lfsr_q[WIDTH-1:1]};
            ST_INJECT: lfsr_d = err_ctrl_q ? (lfsr_q ^ INJ_MASK) : (lfsr_q & ~INJ_MASK);
            default:   lfsr_d = lfsr_q;
        endcase
    end

    assign chain_d = (state_q == ST_CAPTURE) ? lfsr_q : chain_q;

`ifdef DUMP_PARITY_EN
    assign dump_vec = {^chain_d, chain_d};
`else
    assign dump_vec = chain_d;
`endif

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        slot_d     = DUMP_LOAD - tmr_d;
        err_ctrl_d = (state_q == ST_DONE) ? ~err_ctrl_q : err_ctrl_q;
        err_en_d   = (state_d == ST_INJECT);
        c_en_d     = (state_d == ST_CAPTURE);
        dump_en_d  = (state_d == ST_DUMP);
        sh_rst_d   = (state_d == ST_IDLE);
        done_d     = (state_d == ST_DONE);
        sh_clk_d   = dump_en_d & slot_d[0];
        vld_d      = dump_en_d & slot_d[0];
        ch_out_d   = dump_en_d & (|(dump_vec & (SLOT_ONE << slot_d[TMR_W-1:1])));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            lfsr_q     <= SEED;
            chain_q    <= '0;
            err_ctrl_q <= 1'b1;
            err_en_q   <= 1'b0;
            c_en_q     <= 1'b0;
            dump_en_q  <= 1'b0;
            sh_clk_q   <= 1'b0;
            sh_rst_q   <= 1'b1;
            ch_out_q   <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            lfsr_q     <= lfsr_d;
            chain_q    <= chain_d;
            err_ctrl_q <= err_ctrl_d;
            err_en_q   <= err_en_d;
            c_en_q     <= c_en_d;
            dump_en_q  <= dump_en_d;
            sh_clk_q   <= sh_clk_d;
            sh_rst_q   <= sh_rst_d;
            ch_out_q   <= ch_out_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
        end
    end

    assign probe.out         = lfsr_q[0];
    assign probe.err_en      = err_en_q;
    assign probe.err_ctrl    = err_ctrl_q;
    assign probe.sh_clk      = sh_clk_q;
    assign probe.sh_rst      = sh_rst_q;
    assign probe.c_en        = c_en_q;
    assign probe.dump_en     = dump_en_q;
    assign probe.ch_out      = ch_out_q;
    assign probe.ch_out_vld  = vld_q;
    assign probe.ch_out_done = done_q;

endmodule

// File: tb/tb_scan_inject_base.sv
// Bench for scan_inject_base: phase-table timing checks, LFSR model and capture scoreboard,
// plus a second instance exercising the lock-up guard and clearing an already-zero bit.
module tb_scan_inject_base;

    localparam int W = 16;
`ifdef DUMP_PARITY_EN
    localparam int NSLOT = W + 1;
`else
    localparam int NSLOT = W;
`endif
    localparam int DC    = 2 * NSLOT;
    localparam int PASS  = 32 + 3 + DC;
    localparam int N_END = 2 * PASS + 40;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scan_inject_base_if bus1();
    scan_inject_base_if bus2();

    scan_inject_base dut1 (.clk(clk), .rst(rst), .probe(bus1));

    scan_inject_base #(.SEED(16'h0010), .RUN_CYCLES(1)) dut2 (.clk(clk), .rst(rst), .probe(bus2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        if (s == 16'h0) return SEED;
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [NSLOT-1:0] mk(input logic [15:0] v);
`ifdef DUMP_PARITY_EN
        return {^v, v};
`else
        return v;
`endif
    endfunction

    // {out, err_en, err_ctrl, sh_clk, sh_rst, c_en, dump_en, ch_out, vld, done}
    function automatic logic [9:0] rvec1();
        return {bus1.out, bus1.err_en, bus1.err_ctrl, bus1.sh_clk, bus1.sh_rst,
                bus1.c_en, bus1.dump_en, bus1.ch_out, bus1.ch_out_vld, bus1.ch_out_done};
    endfunction

    function automatic logic [9:0] rvec2();
        return {bus2.out, bus2.err_en, bus2.err_ctrl, bus2.sh_clk, bus2.sh_rst,
                bus2.c_en, bus2.dump_en, bus2.ch_out, bus2.ch_out_vld, bus2.ch_out_done};
    endfunction

    typedef struct {
        int         ph;
        logic [6:0] exp;   // {err_en, c_en, dump_en, sh_clk, vld, done, sh_rst}
    } vec_t;

    logic [NSLOT-1:0] sb1[$];
    logic [NSLOT-1:0] sb2[$];

    // Second instance: its own dump collector, compared against hand-derived captures.
    logic             mon = 1'b0;
    logic [NSLOT-1:0] c2;
    int               c2n = 0;

    always @(negedge clk) begin
        if (mon) begin
            if (bus2.ch_out_vld) begin
                if (c2n < NSLOT) c2[c2n] = bus2.ch_out;
                c2n++;
            end
            if (bus2.ch_out_done) begin
                chk("vld_count2", c2n, NSLOT);
                if (sb2.size() > 0) chk("capture2", c2, sb2.pop_front());
                else chk("sb2_pending", sb2.size(), 1);
                c2n = 0;
            end
        end
    end

    initial begin
        vec_t             tv[9];
        logic [15:0]      model;
        logic [NSLOT-1:0] c1;
        int               c1n, den1, dones1, m, q, p;
        logic [6:0]       flags;

        tv[0] = '{ph: 0,           exp: 7'b0000000};
        tv[1] = '{ph: 31,          exp: 7'b0000000};
        tv[2] = '{ph: 32,          exp: 7'b1000000};
        tv[3] = '{ph: 33,          exp: 7'b0100000};
        tv[4] = '{ph: 34,          exp: 7'b0010000};
        tv[5] = '{ph: 35,          exp: 7'b0011100};
        tv[6] = '{ph: 34 + DC - 2, exp: 7'b0010000};
        tv[7] = '{ph: 34 + DC - 1, exp: 7'b0011100};
        tv[8] = '{ph: 34 + DC,     exp: 7'b0000010};

        // Instance 2: seed 0x0010 steps to 0x0008; flipping bit 3 gives zero, the next
        // step reloads the seed, and clearing its already-zero bit 3 keeps 0x0010.
        sb2.push_back(mk(16'h0000));
        sb2.push_back(mk(16'h0010));
        sb2.push_back(mk(16'h0000));
        sb2.push_back(mk(16'h0010));

        model  = SEED;
        c1n    = 0;
        den1   = 0;
        dones1 = 0;
        c1     = '0;

        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("reset1", rvec1(), 10'b1010100000);
        chk("reset2", rvec2(), 10'b0010100000);

        rst = 1'b1;
        mon = 1'b1;

        for (int n = 0; n <= N_END; n++) begin
            @(posedge clk);
            if (n > 0) begin
                m = n - 1;
                q = m % PASS;
                p = m / PASS;
                if (q < 32) model = lstep(model);
                else if (q == 32) model = (p % 2 == 0) ? (model ^ 16'h0008) : (model & ~16'h0008);
                else if (q == 33) sb1.push_back(mk(model));
            end
            @(negedge clk);
            q = n % PASS;
            if (n == 1) chk("out_first_step", bus1.out, 1'b0);
            chk("out", bus1.out, model[0]);
            chk("err_ctrl", bus1.err_ctrl, ((n / PASS) % 2 == 0));
            flags = {bus1.err_en, bus1.c_en, bus1.dump_en, bus1.sh_clk,
                     bus1.ch_out_vld, bus1.ch_out_done, bus1.sh_rst};
            for (int i = 0; i < 9; i++) begin
                if (tv[i].ph == q) chk($sformatf("flags_ph%0d", q), flags, tv[i].exp);
            end
            if (!bus1.dump_en) chk("ch_out_idle", {bus1.ch_out, bus1.sh_clk}, 2'b00);
            if (bus1.dump_en) den1++;
            if (bus1.ch_out_vld) begin
                if (c1n < NSLOT) c1[c1n] = bus1.ch_out;
                c1n++;
            end
            if (bus1.ch_out_done) begin
                chk("vld_count1", c1n, NSLOT);
                chk("dump_len1", den1, DC);
                if (sb1.size() > 0) chk("capture1", c1, sb1.pop_front());
                else chk("sb1_pending", sb1.size(), 1);
                dones1++;
                c1n  = 0;
                den1 = 0;
            end
        end

        chk("done_count1", dones1, 2);
        chk("sb2_leftover", sb2.size(), 0);

        // Abort mid-DUMP: the very next edge must restore the reset values.
        chk("mid_dump_active", bus1.dump_en, 1'b1);
        mon = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_dump1", rvec1(), 10'b1010100000);
        chk("reset_mid_dump2", rvec2(), 10'b0010100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
